power_mode_fsm: RTL and testbench



---
 rtl/power_mode_fsm.sv | 192 +++++++++++++++++++
 tb/tb_power_mode_fsm.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/power_mode_fsm.sv
// ---------------------------------------------------------------------------
// power_mode_fsm
//   Power-mode controller for the solar-powered node. It picks SLEEP, WAKE,
//   NORMAL, LOW_POWER or ALWAYS_ON from the supply and mode inputs. It drives
//   eight power-domain enables and the system clock-speed select.
//
// Ports
//   i_clk          in   1  system clock; all state changes on the rising edge
//   i_reset        in   1  synchronous, active-high reset
//   i_solar_on     in   1  1 = solar supply present
//   i_always_on    in   1  1 = force full operation regardless of supply/mode
//   i_low_power    in   1  1 = request reduced mode while supplied
//   i_adc_enable   in   1  gate for the ADC domain (enable[1])
//   o_enable       out  8  [0]RTC/wake [1]ADC [2]core [3]mem [4]radio
//                          [5]sensor [6]periph [7]debug
//   o_clockspeed   out  1  1 = fast clock, 0 = slow clock
//
// Optional feature (macro PWR_FSM_STATUS_EN)
//   o_state        out  3  registered state (SLEEP=0 WAKE=1 NORMAL=2
//                          LOW_POWER=3 ALWAYS_ON=4)
//   o_mode_change  out  1  one-cycle pulse on the edge where the state changes
// ---------------------------------------------------------------------------
module power_mode_fsm #(
  parameter int unsigned WAKE_CYCLES = 4,
  parameter logic [7:0]  SLEEP_MASK  = 8'h01,
  parameter logic [7:0]  WAKE_MASK   = 8'h09,
  parameter logic [7:0]  LOWPWR_MASK = 8'h0F,
  parameter logic [7:0]  NORMAL_MASK = 8'hFF
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_solar_on,
  input  logic       i_always_on,
  input  logic       i_low_power,
  input  logic       i_adc_enable,
  output logic [7:0] o_enable,
  output logic       o_clockspeed
`ifdef PWR_FSM_STATUS_EN
  ,
  output logic [2:0] o_state,
  output logic       o_mode_change
`endif
);

  // The encoding doubles as the status code exported on o_state.
  typedef enum logic [2:0] {
    ST_SLEEP     = 3'd0,
    ST_WAKE      = 3'd1,
    ST_NORMAL    = 3'd2,
    ST_LOW_POWER = 3'd3,
    ST_ALWAYS_ON = 3'd4
  } stateT;

  // The wake counter only has to reach WAKE_CYCLES-1, the value it holds
  // during the last WAKE cycle.
  localparam int unsigned CW            = (WAKE_CYCLES > 2) ? $clog2(WAKE_CYCLES) : 1;
  localparam int unsigned WAKE_LAST_INT = (WAKE_CYCLES > 0) ? (WAKE_CYCLES - 1) : 0;
  localparam logic [CW-1:0] WAKE_LAST   = WAKE_LAST_INT[CW-1:0];

  stateT         r_state;
  stateT         w_nextState;
  stateT         w_target;
  logic [CW-1:0] r_wakeCount;
  logic [CW-1:0] w_nextCount;
  logic [7:0]    r_enable;
  logic [7:0]    w_nextEnable;
  logic          r_clockspeed;
  logic          w_nextClockspeed;

  // The target mode is re-evaluated every cycle in strict priority order.
  // always_on overrides everything. A missing supply forces SLEEP. The
  // low_power request then selects between the two supplied modes.
  always_comb begin
    w_target = ST_NORMAL;
    if (i_always_on) begin
      w_target = ST_ALWAYS_ON;
    end else if (!i_solar_on) begin
      w_target = ST_SLEEP;
    end else if (i_low_power) begin
      w_target = ST_LOW_POWER;
    end
  end

  // Next-state logic. Only SLEEP -> NORMAL/LOW_POWER passes through WAKE.
  // ALWAYS_ON is entered without delay from every state. Leaving ALWAYS_ON
  // goes straight to the target. WAKE re-reads the target on its final
  // cycle, so a low_power change during wake-up is honoured. Illegal
  // encodings fall back to SLEEP.
  always_comb begin
    w_nextState = ST_SLEEP;
    w_nextCount = '0;
    case (r_state)
      ST_SLEEP: begin
        if (w_target == ST_SLEEP) begin
          w_nextState = ST_SLEEP;
        end else if ((w_target == ST_ALWAYS_ON) || (WAKE_CYCLES == 0)) begin
          w_nextState = w_target;
        end else begin
          w_nextState = ST_WAKE;
        end
      end
      ST_WAKE: begin
        if ((w_target == ST_ALWAYS_ON) || (w_target == ST_SLEEP)) begin
          w_nextState = w_target;
        end else if (r_wakeCount >= WAKE_LAST) begin
          w_nextState = w_target;
        end else begin
          w_nextState = ST_WAKE;
          w_nextCount = r_wakeCount + CW'(1);
        end
      end
      ST_NORMAL, ST_LOW_POWER, ST_ALWAYS_ON: begin
        w_nextState = w_target;
      end
      default: begin
        w_nextState = ST_SLEEP;
      end
    endcase
  end

  // Output map, decoded from the next state so that the registered outputs
  // change on the same edge as the state. The ADC enable is gated in every
  // mode, so the ADC domain can never be powered while adc_enable is low.
  always_comb begin
    w_nextEnable     = SLEEP_MASK;
    w_nextClockspeed = 1'b0;
    case (w_nextState)
      ST_SLEEP: begin
        w_nextEnable     = SLEEP_MASK;
        w_nextClockspeed = 1'b0;
      end
      ST_WAKE: begin
        w_nextEnable     = WAKE_MASK;
        w_nextClockspeed = 1'b0;
      end
      ST_LOW_POWER: begin
        w_nextEnable     = LOWPWR_MASK;
        w_nextClockspeed = 1'b0;
      end
      ST_NORMAL, ST_ALWAYS_ON: begin
        w_nextEnable     = NORMAL_MASK;
        w_nextClockspeed = 1'b1;
      end
      default: begin
        w_nextEnable     = SLEEP_MASK;
        w_nextClockspeed = 1'b0;
      end
    endcase
    w_nextEnable[1] = w_nextEnable[1] & i_adc_enable;
  end

  // State, wake counter and output registers. The synchronous reset takes
  // priority over every input and returns to SLEEP from any mode.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_SLEEP;
      r_wakeCount  <= '0;
      r_enable     <= SLEEP_MASK;
      r_clockspeed <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_wakeCount  <= w_nextCount;
      r_enable     <= w_nextEnable;
      r_clockspeed <= w_nextClockspeed;
    end
  end

  assign o_enable     = r_enable;
  assign o_clockspeed = r_clockspeed;

`ifdef PWR_FSM_STATUS_EN
  logic [2:0] r_statusState;
  logic       r_modeChange;

  // Status outputs are registered with the other outputs. The mode-change
  // pulse is forced low during reset, even when reset knocks the FSM out
  // of another mode.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_statusState <= ST_SLEEP;
      r_modeChange  <= 1'b0;
    end else begin
      r_statusState <= w_nextState;
      r_modeChange  <= (w_nextState != r_state);
    end
  end

  assign o_state       = r_statusState;
  assign o_mode_change = r_modeChange;
`endif

endmodule

// File: tb/tb_power_mode_fsm.sv
// ---------------------------------------------------------------------------
// tb_power_mode_fsm
//   Directed bench for power_mode_fsm with default parameters
//   (WAKE_CYCLES=4). Each step drives the inputs, clocks one rising edge and
//   compares the registered outputs against hand-computed values. When the
//   design is built with PWR_FSM_STATUS_EN, the status outputs are checked
//   as well.
// ---------------------------------------------------------------------------
module tb_power_mode_fsm;

  logic       clk;
  logic       reset;
  logic       solarOn;
  logic       alwaysOn;
  logic       lowPower;
  logic       adcEnable;
  logic [7:0] enable;
  logic       clockspeed;
`ifdef PWR_FSM_STATUS_EN
  logic [2:0] stateOut;
  logic       modeChange;
  logic [2:0] prevExpState;
`endif

  int vecCount;
  int failCount;

  localparam logic [2:0] S_SLEEP = 3'd0;
  localparam logic [2:0] S_WAKE  = 3'd1;
  localparam logic [2:0] S_NORM  = 3'd2;
  localparam logic [2:0] S_LOWP  = 3'd3;
  localparam logic [2:0] S_AON   = 3'd4;

  power_mode_fsm dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_solar_on   (solarOn),
    .i_always_on  (alwaysOn),
    .i_low_power  (lowPower),
    .i_adc_enable (adcEnable),
    .o_enable     (enable),
    .o_clockspeed (clockspeed)
`ifdef PWR_FSM_STATUS_EN
    ,
    .o_state      (stateOut),
    .o_mode_change(modeChange)
`endif
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of inputs, then sample 1 ns after the next rising edge.
  task automatic applyStimulus(input logic rst, input logic solar, input logic aon,
                               input logic lowp, input logic adc);
    reset     = rst;
    solarOn   = solar;
    alwaysOn  = aon;
    lowPower  = lowp;
    adcEnable = adc;
    @(posedge clk);
    #1;
  endtask

  // Compare the outputs with the expected values for the current step.
  task automatic checkOutput(input string tag, input logic [7:0] expEnable,
                             input logic expSpeed, input logic [2:0] expState);
    vecCount++;
    assert (enable === expEnable) else begin
      failCount++;
      $error("[TB] FAIL %s enable: observed %h expected %h", tag, enable, expEnable);
    end
    vecCount++;
    assert (clockspeed === expSpeed) else begin
      failCount++;
      $error("[TB] FAIL %s clockspeed: observed %b expected %b", tag, clockspeed, expSpeed);
    end
`ifdef PWR_FSM_STATUS_EN
    vecCount++;
    assert (stateOut === expState) else begin
      failCount++;
      $error("[TB] FAIL %s state: observed %0d expected %0d", tag, stateOut, expState);
    end
    vecCount++;
    assert (modeChange === ((expState != prevExpState) && !reset)) else begin
      failCount++;
      $error("[TB] FAIL %s mode_change: observed %b expected %b", tag, modeChange,
             ((expState != prevExpState) && !reset));
    end
    prevExpState = expState;
`else
    if (expState > S_AON) $display("[TB] note: unexpected state code in %s", tag);
`endif
  endtask

  initial begin
    vecCount  = 0;
    failCount = 0;
`ifdef PWR_FSM_STATUS_EN
    prevExpState = S_SLEEP;
`endif

    // Reset held for two clocks with every input low.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset", 8'h01, 1'b0, S_SLEEP);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_release", 8'h01, 1'b0, S_SLEEP);

    // Wake path: four WAKE cycles, then NORMAL.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("wake_c1", 8'h09, 1'b0, S_WAKE);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("wake_c2", 8'h09, 1'b0, S_WAKE);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("wake_c3", 8'h09, 1'b0, S_WAKE);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("wake_c4", 8'h09, 1'b0, S_WAKE);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("normal", 8'hFF, 1'b1, S_NORM);

    // ADC gate while in NORMAL.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("adc_gate_norm", 8'hFD, 1'b1, S_NORM);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("adc_ungate", 8'hFF, 1'b1, S_NORM);

    // Override and low power.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("aon_from_norm", 8'hFF, 1'b1, S_AON);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("aon_holds", 8'hFF, 1'b1, S_AON);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("aon_to_lowp", 8'h0F, 1'b0, S_LOWP);

    // Sleep entry from LOW_POWER.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("lowp_to_sleep", 8'h01, 1'b0, S_SLEEP);

    // Supply lost during WAKE cycle 2.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("wake2_c1", 8'h09, 1'b0, S_WAKE);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("wake2_c2", 8'h09, 1'b0, S_WAKE);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("wake_abort", 8'h01, 1'b0, S_SLEEP);

    // always_on from SLEEP with the ADC gated off.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("aon_from_sleep_adc0", 8'hFD, 1'b1, S_AON);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("aon_to_sleep", 8'h01, 1'b0, S_SLEEP);

    // Priority: always_on wins over missing supply and low_power.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("priority_aon", 8'hFF, 1'b1, S_AON);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("priority_release", 8'h01, 1'b0, S_SLEEP);

    // Reset asserted mid-WAKE returns to SLEEP on that edge.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("wake3_c1", 8'h09, 1'b0, S_WAKE);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("wake3_c2", 8'h09, 1'b0, S_WAKE);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("reset_mid_wake", 8'h01, 1'b0, S_SLEEP);

    // A fresh wake-up that ends in LOW_POWER because low_power rose during WAKE.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("wake4_c1", 8'h09, 1'b0, S_WAKE);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("wake4_c2", 8'h09, 1'b0, S_WAKE);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("wake4_c3", 8'h09, 1'b0, S_WAKE);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("wake4_c4", 8'h09, 1'b0, S_WAKE);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("wake_to_lowp", 8'h0F, 1'b0, S_LOWP);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("lowp_to_norm", 8'hFF, 1'b1, S_NORM);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("norm_to_lowp_adc0", 8'h0D, 1'b0, S_LOWP);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

endmodule
